// File: rtl/snake_field_reader.sv
// rtl/snake_field_reader.sv - snapshots the packed snake field and streams it one cell per beat
// with per-frame snake length, apple count and invalid-code statistics.
module snake_field_reader #(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int FIELD_SIZE = SIZE_X * SIZE_Y * 3,
    parameter int XBITS      = $clog2(SIZE_X),
    parameter int YBITS      = $clog2(SIZE_Y),
    parameter int CBITS      = $clog2(SIZE_X * SIZE_Y + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIELD_SIZE-1:0] field,
    input  logic                  frame_req,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XBITS-1:0]      out_x,
    output logic [YBITS-1:0]      out_y,
    output logic [2:0]            out_cell,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  frame_done,
    output logic [CBITS-1:0]      snake_len,
    output logic [CBITS-1:0]      apple_cnt,
    output logic                  bad_cell
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [XBITS-1:0] XMAX = XBITS'(SIZE_X - 1);
    localparam logic [YBITS-1:0] YMAX = YBITS'(SIZE_Y - 1);

    state_t                  state;
    state_t                  state_next;
    logic [FIELD_SIZE-1:0]   snap;
    logic [CBITS-1:0]        run_snake;
    logic [CBITS-1:0]        run_apple;
    logic                    run_bad;
    logic                    accept;
    logic                    last;
    logic                    is_snake;
    logic                    is_apple;
    logic                    is_bad;

    // The snapshot shifts down one cell per accept, so the current cell always sits at the bottom.
    assign out_cell   = snap[2:0];
    assign accept     = out_valid & out_ready;
    assign last       = (out_x == XMAX) && (out_y == YMAX);
    assign is_snake   = (out_cell != 3'd0) && (out_cell <= 3'd4);
    assign is_apple   = (out_cell == 3'd5);
    assign is_bad     = (out_cell >= 3'd6);
    assign out_sof    = out_valid && (out_x == '0) && (out_y == '0);
    assign out_eof    = out_valid && last;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_req) state_next = STREAM;
            STREAM:  if (accept && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap      <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            run_snake <= '0;
            run_apple <= '0;
            run_bad   <= 1'b0;
            snake_len <= '0;
            apple_cnt <= '0;
            bad_cell  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_req) begin
                        snap      <= field;
                        out_valid <= 1'b1;
                        out_x     <= '0;
                        out_y     <= '0;
                        run_snake <= '0;
                        run_apple <= '0;
                        run_bad   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        snap      <= {3'b000, snap[FIELD_SIZE-1:3]};
                        run_snake <= run_snake + CBITS'(is_snake);
                        run_apple <= run_apple + CBITS'(is_apple);
                        run_bad   <= run_bad | is_bad;
                        if (last) begin
                            // Totals include the last cell so they are valid alongside frame_done.
                            out_valid <= 1'b0;
                            out_x     <= '0;
                            out_y     <= '0;
                            snake_len <= run_snake + CBITS'(is_snake);
                            apple_cnt <= run_apple + CBITS'(is_apple);
                            bad_cell  <= run_bad | is_bad;
                        end else if (out_x == XMAX) begin
                            out_x <= '0;
                            out_y <= out_y + 1'b1;
                        end else begin
                            out_x <= out_x + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_field_reader.sv
// tb/tb_snake_field_reader.sv - directed self-checking bench for snake_field_reader.
module tb_snake_field_reader;

    localparam int FS = 300;

    logic          clk;
    logic          rst;
    logic [FS-1:0] field;
    logic          frame_req;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_x;
    logic [3:0]    out_y;
    logic [2:0]    out_cell;
    logic          out_sof;
    logic          out_eof;
    logic          frame_done;
    logic [6:0]    snake_len;
    logic [6:0]    apple_cnt;
    logic          bad_cell;

    int checks = 0;
    int errors = 0;

    snake_field_reader dut (
        .clk        (clk),
        .rst        (rst),
        .field      (field),
        .frame_req  (frame_req),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_cell   (out_cell),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .snake_len  (snake_len),
        .apple_cnt  (apple_cnt),
        .bad_cell   (bad_cell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FS-1:0] set_cell(input logic [FS-1:0] f, input int x, input int y,
                                               input logic [2:0] c);
        logic [FS-1:0] r;
        r = f;
        r[(y * 10 + x) * 3 +: 3] = c;
        return r;
    endfunction

    // Beat word layout: {sof, eof, y, x, cell}
    function automatic logic [12:0] exp_word(input logic [FS-1:0] f, input int k);
        logic [2:0] c;
        logic [3:0] bx;
        logic [3:0] by;
        c  = f[k * 3 +: 3];
        bx = 4'(k % 10);
        by = 4'(k / 10);
        return {(k == 0), (k == 99), by, bx, c};
    endfunction

    // mode: 0 always ready, 1 alternating ready, 2 random stalls
    // inject: 3 modify field at cycle 10, 4 extra frame_req at beats 3 and 50
    task automatic run_frame(input string nm, input logic [FS-1:0] f, input int mode, input int inject,
                             input int es, input int ea, input int eb);
        int   k;
        int   done_cyc;
        logic rdy;
        field    = f;
        k        = 0;
        done_cyc = 0;
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        check({nm, "_latency"}, 32'(out_valid), 32'd1);
        check({nm, "_busy"}, 32'(busy), 32'd1);
        for (int cyc = 1; cyc < 2000 && done_cyc == 0; cyc++) begin
            if (frame_done) begin
                done_cyc = cyc;
            end else begin
                if (out_valid) begin
                    if (k > 99) check({nm, "_extra_beat"}, 32'd1, 32'd0);
                    else check({nm, "_beat"}, 32'({out_sof, out_eof, out_y, out_x, out_cell}),
                               32'(exp_word(f, k)));
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 2 == 1);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                out_ready = rdy;
                frame_req = (inject == 4) && (k == 3 || k == 50);
                if (inject == 3 && cyc == 10) field = set_cell(field, 5, 5, 3'd5);
                if (out_valid && rdy) k++;
                @(posedge clk); #1;
            end
        end
        frame_req = 1'b0;
        check({nm, "_done_seen"}, 32'(done_cyc != 0), 32'd1);
        check({nm, "_beat_count"}, 32'(k), 32'd100);
        if (mode == 0) check({nm, "_done_cycle"}, 32'(done_cyc), 32'd101);
        check({nm, "_busy_at_done"}, 32'(busy), 32'd1);
        check({nm, "_snake_len"}, 32'(snake_len), 32'(es));
        check({nm, "_apple_cnt"}, 32'(apple_cnt), 32'(ea));
        check({nm, "_bad_cell"}, 32'(bad_cell), 32'(eb));
        @(posedge clk); #1;
        check({nm, "_done_pulse"}, 32'(frame_done), 32'd0);
        check({nm, "_busy_after"}, 32'(busy), 32'd0);
        if (inject == 4) begin
            for (int i = 0; i < 3; i++) begin
                check({nm, "_no_restart"}, 32'({out_valid, frame_done}), 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    logic [FS-1:0] f1;
    logic [FS-1:0] f2;
    logic [FS-1:0] f3;

    initial begin
        rst       = 1'b0;
        field     = '0;
        frame_req = 1'b0;
        out_ready = 1'b0;
        f1 = '0;
        f1 = set_cell(f1, 0, 0, 3'd5);
        for (int x = 1; x <= 4; x++) f1 = set_cell(f1, x, 1, 3'd2);
        f2 = set_cell(f1, 5, 5, 3'd5);
        f3 = set_cell(f1, 9, 9, 3'd7);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({busy, out_valid, out_x, out_y, out_cell, out_sof, out_eof, frame_done}), 32'd0);
        check("reset_stats", 32'({snake_len, apple_cnt, bad_cell}), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_frame("basic", f1, 0, 0, 4, 1, 0);
        run_frame("toggle", f1, 1, 0, 4, 1, 0);
        run_frame("random", f1, 2, 0, 4, 1, 0);
        run_frame("tear", f1, 0, 3, 4, 1, 0);
        run_frame("tear_next", f2, 0, 0, 4, 2, 0);
        run_frame("ignore_req", f1, 0, 4, 4, 1, 0);
        run_frame("bad", f3, 0, 0, 4, 1, 1);
        run_frame("clean", f1, 0, 0, 4, 1, 0);

        field     = f1;
        out_ready = 1'b1;
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_beat40", 32'({out_valid, out_y, out_x}), 32'({1'b1, 4'd4, 4'd0}));
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_snake_len", 32'(snake_len), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_no_done", 32'(frame_done), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_idle", 32'({busy, out_valid, frame_done}), 32'd0);
        run_frame("after_rst", f1, 0, 0, 4, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
